// File: rtl/div_unit_if.sv
// Request/response bundle between the EX stage and the iterative divider.
//   master: EX stage (drives the operands, start_i and annul_i; receives result_o and ready_o)
//   slave : div_unit (the reverse directions)
interface div_unit_if;
  localparam int unsigned DATA_W = 32;

  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_unit.sv
// Iterative 32-bit restoring divider (DIV/DIVU) for the EX stage.
// The divider produces one quotient bit per cycle and writes {remainder, quotient} to HI/LO.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : div_unit_if.slave
//         inputs  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i
//         outputs result_o (registered) and ready_o (registered)
module div_unit (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  localparam int unsigned DW = 32;
  localparam int unsigned WW = 2 * DW + 1;
  localparam int unsigned CW = 6;
  localparam logic [CW-1:0] STEPS = CW'(DW);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WW-1:0]   work_q, work_d;
  logic [DW-1:0]   divisor_q, divisor_d;
  logic            neg_quot_q, neg_quot_d;
  logic            neg_rem_q, neg_rem_d;
  logic [2*DW-1:0] result_q, result_d;
  logic            ready_q, ready_d;

  // Operand magnitudes; only signed mode takes absolute values.
  logic [DW-1:0]   dividend_abs_c, divisor_abs_c;
  // One restoring step on the working register.
  logic [WW-1:0]   shifted_c;
  logic [DW:0]     trial_c;
  logic            take_c;
  // Sign-corrected result halves.
  logic [DW-1:0]   quot_c, rem_c;

  always_comb begin
    dividend_abs_c = (bus.signed_div_i && bus.opdata1_i[DW-1]) ?
                     (~bus.opdata1_i + DW'(1)) : bus.opdata1_i;
    divisor_abs_c  = (bus.signed_div_i && bus.opdata2_i[DW-1]) ?
                     (~bus.opdata2_i + DW'(1)) : bus.opdata2_i;
  end

  // A set top bit would mean the shifted partial remainder is at least 2^33,
  // which can only be non-negative after subtraction, so it forces a take.
  always_comb begin
    shifted_c = {work_q[WW-2:0], 1'b0};
    trial_c   = shifted_c[WW-1:DW] - {1'b0, divisor_q};
    take_c    = !trial_c[DW] || work_q[WW-1];
    quot_c    = neg_quot_q ? (~work_q[DW-1:0] + DW'(1)) : work_q[DW-1:0];
    rem_c     = neg_rem_q  ? (~work_q[2*DW-1:DW] + DW'(1)) : work_q[2*DW-1:DW];
  end

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    divisor_d  = divisor_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    ready_d    = ready_q;

    unique case (state_q)
      FREE: begin
        cnt_d    = '0;
        result_d = '0;
        ready_d  = 1'b0;
        if (bus.start_i && !bus.annul_i) begin
          neg_quot_d = bus.signed_div_i && (bus.opdata1_i[DW-1] ^ bus.opdata2_i[DW-1]);
          neg_rem_d  = bus.signed_div_i && bus.opdata1_i[DW-1];
          divisor_d  = divisor_abs_c;
          work_d     = {(DW+1)'(0), dividend_abs_c};
          state_d    = (bus.opdata2_i == '0) ? BYZERO : ON;
        end
      end

      BYZERO: begin
        if (bus.annul_i) begin
          state_d  = FREE;
          cnt_d    = '0;
          result_d = '0;
          ready_d  = 1'b0;
        end else begin
          state_d  = END;
          result_d = '0;
          ready_d  = 1'b1;
        end
      end

      ON: begin
        if (bus.annul_i) begin
          state_d  = FREE;
          cnt_d    = '0;
          work_d   = '0;
          result_d = '0;
          ready_d  = 1'b0;
        end else if (cnt_q == STEPS) begin
          state_d  = END;
          result_d = {rem_c, quot_c};
          ready_d  = 1'b1;
        end else begin
          work_d = take_c ? {trial_c, shifted_c[DW-1:1], 1'b1} : shifted_c;
          cnt_d  = cnt_q + CW'(1);
        end
      end

      END: begin
        ready_d = 1'b1;
        if (!bus.start_i) begin
          state_d  = FREE;
          cnt_d    = '0;
          result_d = '0;
          ready_d  = 1'b0;
        end
      end

      default: state_d = FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FREE;
      cnt_q      <= '0;
      work_q     <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      divisor_q  <= divisor_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed + small random bench for div_unit with a result/latency scoreboard.
module tb_div_unit;

  typedef struct {
    string       tag;
    logic [63:0] res;
    int          lat;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  exp_t sb_q[$];

  div_unit_if bus ();

  div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Independent reference: magnitudes, then sign fix-up of each half.
  function automatic logic [63:0] model(input logic sd, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ua, ub, q, r;
    if (b == 32'h0) return 64'h0;
    ua = (sd && a[31]) ? (32'h0 - a) : a;
    ub = (sd && b[31]) ? (32'h0 - b) : b;
    q  = ua / ub;
    r  = ua % ub;
    if (sd && (a[31] ^ b[31])) q = 32'h0 - q;
    if (sd && a[31])           r = 32'h0 - r;
    return {r, q};
  endfunction

  // Drive a request, scramble operands while busy, then check result, latency,
  // stability in END (annul ignored) and the release back to FREE.
  task automatic run_op(input string tag, input logic sd, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] res, input int lat);
    exp_t        e;
    int          n;
    logic [63:0] held;
    e.tag = tag; e.res = res; e.lat = lat;
    sb_q.push_back(e);
    bus.signed_div_i = sd;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        bus.opdata1_i    = $urandom;
        bus.opdata2_i    = $urandom;
        bus.signed_div_i = ~sd;
      end
    end while (!bus.ready_o && n < 100);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd1);
      return;
    end
    e = sb_q.pop_front();
    check({e.tag, "_lat"}, 64'(n), 64'(e.lat));
    check({e.tag, "_res"}, bus.result_o, e.res);
    held = bus.result_o;
    bus.annul_i   = 1'b1;
    bus.opdata1_i = $urandom;
    @(negedge clk);
    check({e.tag, "_hold"}, {bus.ready_o, bus.result_o}, {1'b1, held});
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    @(negedge clk);
    check({e.tag, "_release"}, {bus.ready_o, bus.result_o}, 65'h0);
  endtask

  initial begin
    int          highs;
    int          n;
    logic [31:0] ra, rb;
    logic        rs;
    checks   = 0;
    failures = 0;
    rst              = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    #12;
    check("reset_state", {bus.ready_o, bus.result_o}, 65'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("idle_free", {bus.ready_o, bus.result_o}, 65'h0);

    run_op("u_100_7",    1'b0, 32'd100,      32'd7,        {32'd2, 32'd14},                34);
    run_op("s_m7_2",     1'b1, 32'hFFFFFFF9, 32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD},  34);
    run_op("s_7_m2",     1'b1, 32'd7,        32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD},  34);
    run_op("u_div0",     1'b0, 32'd1234,     32'd0,        64'h0,                          2);
    run_op("s_div0",     1'b1, 32'hFFFFFF00, 32'd0,        64'h0,                          2);
    run_op("s_ovf",      1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000},         34);
    run_op("u_max_1",    1'b0, 32'hFFFFFFFF, 32'd1,        {32'h0, 32'hFFFFFFFF},         34);
    run_op("u_small_big",1'b0, 32'd5,        32'hFFFFFFFF, {32'd5, 32'd0},                34);

    for (int i = 0; i < 4; i++) begin
      rs = 1'(i[0]);
      ra = $urandom;
      rb = $urandom_range(1, 32'h0000FFFF);
      if (i == 3) rb = rb | 32'h80000000;
      run_op($sformatf("rand%0d", i), rs, ra, rb, model(rs, ra, rb), 34);
    end

    // Annul at ON step 10 (counter reaches 10 after edge 11).
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd100;
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    repeat (11) @(negedge clk);
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    @(negedge clk);
    bus.annul_i = 1'b0;
    check("annul_free", {bus.ready_o, bus.result_o}, 65'h0);
    highs = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.ready_o) highs++;
    end
    check("annul_no_result", 64'(highs), 64'd0);
    run_op("u_50_5", 1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 34);

    // Reset between edges while in ON.
    bus.opdata1_i = 32'd1000;
    bus.opdata2_i = 32'd3;
    bus.start_i   = 1'b1;
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1 check("rst_in_on", {bus.ready_o, bus.result_o}, 65'h0);
    bus.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    highs = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.ready_o) highs++;
    end
    check("rst_no_resume", 64'(highs), 64'd0);

    // Reset between edges while in END, result is non-zero beforehand.
    bus.opdata1_i = 32'd9;
    bus.opdata2_i = 32'd3;
    bus.start_i   = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.ready_o && n < 100);
    check("end_before_rst", {bus.ready_o, bus.result_o}, {1'b1, 32'd0, 32'd3});
    #2 rst = 1'b0;
    #1 check("rst_in_end", {bus.ready_o, bus.result_o}, 65'h0);
    bus.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("after_rst_free", {bus.ready_o, bus.result_o}, 65'h0);
    run_op("u_after_rst", 1'b0, 32'd77, 32'd10, {32'd7, 32'd7}, 34);

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
